// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, control codes, FSM states and control bundle for alu_sequencer
package alu_seq_pkg;

    localparam int SEQ_W = 10;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_LI   = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_EQ  = 2'b10;
    localparam logic [1:0] ALU_LT  = 2'b11;

    localparam logic [1:0] WV_ALU = 2'b00;
    localparam logic [1:0] WV_PC  = 2'b01;
    localparam logic [1:0] WV_IMM = 2'b10;
    localparam logic [1:0] WV_RB  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    // Everything the sequencer presents to the register file / ALU, registered as one bundle.
    typedef struct packed {
        logic [1:0]       ra;
        logic [1:0]       rb;
        logic [1:0]       wa;
        logic             we;
        logic [1:0]       alu_op;
        logic [1:0]       wv_op;
        logic [SEQ_W-1:0] imm;
        logic [SEQ_W-1:0] pcv;
    } ctrl_t;

    function automatic logic [SEQ_W-1:0] sext5(input logic [4:0] v);
        return {{(SEQ_W-5){v[4]}}, v};
    endfunction

    function automatic logic [SEQ_W-1:0] sext3(input logic [2:0] v);
        return {{(SEQ_W-3){v[2]}}, v};
    endfunction

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational instruction decoder for alu_sequencer
module seq_decode
    import alu_seq_pkg::*;
(
    input  logic [SEQ_W-1:0] instr,
    output logic [1:0]       rd,
    output logic [1:0]       rs,
    output logic [1:0]       alu_op,
    output logic [1:0]       wv_op,
    output logic [SEQ_W-1:0] imm_sext,
    output logic [SEQ_W-1:0] br_off,
    output logic             writes_rf,
    output logic             is_jal,
    output logic             is_beq,
    output logic             is_halt,
    output logic             is_illegal
);

    logic [2:0] opcode;

    always_comb begin
        opcode     = instr[9:7];
        rd         = instr[6:5];
        rs         = instr[4:3];
        imm_sext   = sext5(instr[4:0]);
        br_off     = sext3(instr[2:0]);
        alu_op     = ALU_ADD;
        wv_op      = WV_ALU;
        writes_rf  = 1'b0;
        is_jal     = 1'b0;
        is_beq     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ALU: begin
                alu_op    = instr[1:0];
                writes_rf = 1'b1;
            end
            OP_LI: begin
                wv_op     = WV_IMM;
                writes_rf = 1'b1;
            end
            OP_MOV: begin
                wv_op     = WV_RB;
                writes_rf = 1'b1;
            end
            OP_JAL: begin
                wv_op     = WV_PC;
                writes_rf = 1'b1;
                is_jal    = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_EQ;
                is_beq = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/exec/writeback sequencer driving the 10-bit ALU datapath
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int                DATA_W   = SEQ_W,
    parameter logic [DATA_W-1:0] PC_RESET = 10'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic [1:0]        rf_ra,
    output logic [1:0]        rf_rb,
    output logic [1:0]        rf_wa,
    output logic              rf_we,
    output logic [1:0]        alu_operation,
    output logic [1:0]        writeval_op,
    output logic [DATA_W-1:0] imm_val,
    output logic [DATA_W-1:0] pcvalue,
    input  logic              alu_result,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic              flag_q, flag_d;
    ctrl_t             ctrl_q, ctrl_d;

    logic [1:0]        dec_rd, dec_rs, dec_alu_op, dec_wv_op;
    logic [DATA_W-1:0] dec_imm, dec_br_off;
    logic              dec_writes, dec_jal, dec_beq, dec_halt, dec_illegal;
    logic [DATA_W-1:0] pc_inc;

    seq_decode u_decode (
        .instr      (ir_q),
        .rd         (dec_rd),
        .rs         (dec_rs),
        .alu_op     (dec_alu_op),
        .wv_op      (dec_wv_op),
        .imm_sext   (dec_imm),
        .br_off     (dec_br_off),
        .writes_rf  (dec_writes),
        .is_jal     (dec_jal),
        .is_beq     (dec_beq),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    assign pc_inc = pc_q + DATA_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        flag_d    = flag_q;
        ctrl_d    = ctrl_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = PC_RESET;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_halt || dec_illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = dec_illegal;
                end else begin
                    ctrl_d.ra     = dec_rd;
                    ctrl_d.rb     = dec_rs;
                    ctrl_d.wa     = dec_rd;
                    ctrl_d.we     = 1'b0;
                    ctrl_d.alu_op = dec_alu_op;
                    ctrl_d.wv_op  = dec_wv_op;
                    ctrl_d.imm    = dec_imm;
                    ctrl_d.pcv    = pc_inc;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                flag_d    = alu_result;
                ctrl_d.we = dec_writes;
                state_d   = ST_WB;
            end
            ST_WB: begin
                // Clearing the bundle here drops rf_we after exactly one cycle.
                ctrl_d = '0;
                if (dec_jal) begin
                    pc_d = pc_inc + dec_imm;
                end else if (dec_beq && flag_q) begin
                    pc_d = pc_inc + dec_br_off;
                end else begin
                    pc_d = pc_inc;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = PC_RESET;
                    illegal_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctrl_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            flag_q    <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            flag_q    <= flag_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign imem_req      = (state_q == ST_FETCH);
    assign imem_addr     = pc_q;
    assign halted        = (state_q == ST_HALT);
    assign illegal       = illegal_q;
    assign rf_ra         = ctrl_q.ra;
    assign rf_rb         = ctrl_q.rb;
    assign rf_wa         = ctrl_q.wa;
    assign rf_we         = ctrl_q.we;
    assign alu_operation = ctrl_q.alu_op;
    assign writeval_op   = ctrl_q.wv_op;
    assign imm_val       = ctrl_q.imm;
    assign pcvalue       = ctrl_q.pcv;

endmodule
